e203_eai_copro: RTL and testbench
=================================

E203_EAI_COPRO -- requirements
Module: e203_eai_copro

Interface
REQ-001 SHALL have parameter MUL_BPC, default 1: multiplier bits retired per cycle; legal values 1, 2, 4.
REQ-002 SHALL have parameter XLEN, default 32: operand, accumulator and result width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 eai_req_valid  input  1  request handshake valid, from EAI issue stage.
REQ-006 eai_req_ready  output  1  request handshake ready.
REQ-007 eai_req_instr  input  XLEN  instruction word.
REQ-008 eai_req_rs1  input  XLEN  operand 1.
REQ-009 eai_req_rs2  input  XLEN  operand 2.
REQ-010 eai_rsp_valid  output  1  response valid; drives EAI eai_rsp_multicyc_valid.
REQ-011 eai_rsp_ready  input  1  response ready; from EAI eai_rsp_multicyc_ready.
REQ-012 eai_rsp_rdat  output  XLEN  result data.
REQ-013 eai_rsp_err  output  1  illegal-instruction flag.
REQ-014 copro_busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RSP; eai_req_ready = (state==IDLE).
REQ-016 On request handshake, SHALL capture instr, rs1 and rs2 into internal registers; inputs are ignored afterwards.
REQ-017 SHALL decode opcode instr[6:0]==7'b0001011 and funct3 instr[14:12]: 000 MUL, 001 MAC, 010 RDACC, 011 CLR; any other opcode or funct3 is ILLEGAL.
REQ-018 MUL: rdat = low XLEN bits of rs1*rs2 (unsigned); accumulator unchanged.
REQ-019 MAC: acc <= acc + low(rs1*rs2) mod 2^XLEN; rdat = the new acc value.
REQ-020 RDACC: rdat = acc.
REQ-021 CLR: rdat = the old acc value; acc <= 0.
REQ-022 ILLEGAL: rdat = 0 and err = 1; acc unchanged; err = 0 for all legal ops.
REQ-023 MUL/MAC: IDLE->EXEC on accept in cycle T; EXEC lasts N = XLEN/MUL_BPC cycles (T+1..T+N) using shift-add on MUL_BPC bits per cycle; EXEC->RSP after the Nth cycle; eai_rsp_valid first high at T+N+1.
REQ-024 RDACC/CLR/ILLEGAL: IDLE->RSP on accept; eai_rsp_valid high at T+1.
REQ-025 In RSP, eai_rsp_valid SHALL stay high and rdat/err SHALL stay stable until eai_rsp_ready; on handshake, RSP->IDLE.
REQ-026 The accumulator update for MAC/CLR SHALL occur on entry to RSP, not at response handshake.
REQ-027 eai_rsp_valid SHALL be 0 in IDLE and EXEC; at most one request outstanding; minimum issue interval 2 cycles.
REQ-028 eai_req_ready SHALL NOT depend combinationally on eai_rsp_ready; no combinational path from any input to eai_rsp_valid.
REQ-029 The EXEC counter SHALL be log2(N)+1 bits wide and SHALL NOT wrap.

Reset
REQ-030 rst SHALL force: state IDLE, acc 0, eai_rsp_valid 0, eai_rsp_rdat 0, eai_rsp_err 0, counter 0, copro_busy 0.
REQ-031 rst asserted in EXEC or RSP SHALL abort the operation, produce no response, and set eai_req_ready=1 in the first cycle after rst deasserts.
REQ-032 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-033 Opcode constant, funct3 codes and FSM state encoding SHALL reside in the shared e203 defines package.
REQ-034 The iterative multiplier SHALL be a sub-module e203_eai_copro_mul (start, operands, done, product; MUL_BPC parameter); the FSM and accumulator stay in the top.

Verification
REQ-035 MUL rs1=3, rs2=5, MUL_BPC=1, rsp_ready=1 -> rsp_valid at T+33, rdat=15, err=0.
REQ-036 MAC rs1=0xFFFFFFFF, rs2=2 with acc=0, then RDACC -> rdat=0xFFFFFFFE for both; MAC rs1=1, rs2=2 next -> rdat=0x00000000 (wrap).
REQ-037 CLR with acc=0x12345678 -> rdat=0x12345678; following RDACC -> rdat=0.
REQ-038 funct3=111 -> rsp_valid at T+1, rdat=0, err=1; acc unchanged.
REQ-039 Hold rsp_ready=0 for 10 cycles in RSP -> valid, rdat and err stable; req_ready=0 throughout; IDLE one cycle after handshake.
REQ-040 rst pulsed at EXEC cycle 5 of MUL -> no rsp_valid, acc=0, req_ready=1 in the cycle after reset; MUL_BPC=4 rerun -> rsp_valid at T+9.

Source files
------------

// File: rtl/e203_eai_copro_pkg.sv
// Shared definitions for the EAI coprocessor: custom-0 opcode, funct3 codes,
// FSM state encoding, decoded operation type, and the instruction decoder.
package e203_eai_copro_pkg;

  localparam logic [6:0] EAI_OPCODE = 7'b0001011;

  localparam logic [2:0] F3_MUL   = 3'b000;
  localparam logic [2:0] F3_MAC   = 3'b001;
  localparam logic [2:0] F3_RDACC = 3'b010;
  localparam logic [2:0] F3_CLR   = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RSP  = 2'd2
  } copro_state_e;

  typedef enum logic [2:0] {
    OP_MUL     = 3'd0,
    OP_MAC     = 3'd1,
    OP_RDACC   = 3'd2,
    OP_CLR     = 3'd3,
    OP_ILLEGAL = 3'd4
  } copro_op_e;

  // Anything outside the custom-0 opcode or the four funct3 codes is illegal.
  function automatic copro_op_e decode_op(input logic [6:0] opcode,
                                          input logic [2:0] funct3);
    copro_op_e op;
    op = OP_ILLEGAL;
    if (opcode == EAI_OPCODE) begin
      case (funct3)
        F3_MUL:   op = OP_MUL;
        F3_MAC:   op = OP_MAC;
        F3_RDACC: op = OP_RDACC;
        F3_CLR:   op = OP_CLR;
        default:  op = OP_ILLEGAL;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/e203_eai_copro_mul.sv
// Iterative unsigned shift-add multiplier, low XLEN bits of the product.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start            load op_a/op_b and begin; operands are ignored otherwise
//   op_a, op_b       multiplicand and multiplier
//   done             high during the last of the N = XLEN/MUL_BPC step cycles
//   product          final product, valid while done is high
module e203_eai_copro_mul
  import e203_eai_copro_pkg::*;
#(
  parameter int MUL_BPC = 1,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int N  = XLEN / MUL_BPC;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] prod_q, prod_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            active_q, active_d;

  // One partial product per multiplier bit retired this cycle.
  logic [XLEN-1:0] pp [MUL_BPC];
  logic [XLEN-1:0] step_sum;

  for (genvar gi = 0; gi < MUL_BPC; gi++) begin : g_pp
    assign pp[gi] = mplier_q[gi] ? (mcand_q << gi) : '0;
  end

  always_comb begin
    step_sum = '0;
    for (int i = 0; i < MUL_BPC; i++) begin
      step_sum = step_sum + pp[i];
    end
  end

  // The last step's sum is presented combinationally so the caller can
  // commit the result on the same edge that ends the final step.
  assign done    = active_q && (cnt_q == LAST);
  assign product = prod_q + step_sum;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      mcand_d  = op_a;
      mplier_d = op_b;
      prod_d   = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      prod_d   = prod_q + step_sum;
      mcand_d  = mcand_q << MUL_BPC;
      mplier_d = mplier_q >> MUL_BPC;
      // Counter stops at N once the last step retires; it never wraps.
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/e203_eai_copro.sv
// E203 EAI coprocessor: multiply, multiply-accumulate, accumulator read and
// clear over a valid/ready request and multicycle response handshake.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   eai_req_valid/ready            request handshake (ready only in IDLE)
//   eai_req_instr/rs1/rs2          instruction and operands, captured on accept
//   eai_rsp_valid/ready            response handshake (valid only in RSP)
//   eai_rsp_rdat, eai_rsp_err      result data and illegal-instruction flag
//   copro_busy                     high whenever not IDLE
module e203_eai_copro
  import e203_eai_copro_pkg::*;
#(
  parameter int MUL_BPC = 1,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            eai_req_valid,
  output logic            eai_req_ready,
  input  logic [XLEN-1:0] eai_req_instr,
  input  logic [XLEN-1:0] eai_req_rs1,
  input  logic [XLEN-1:0] eai_req_rs2,
  output logic            eai_rsp_valid,
  input  logic            eai_rsp_ready,
  output logic [XLEN-1:0] eai_rsp_rdat,
  output logic            eai_rsp_err,
  output logic            copro_busy
);

  copro_state_e    state_q, state_d;
  copro_op_e       op_q, op_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] rdat_q, rdat_d;
  logic            err_q, err_d;

  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;
  copro_op_e       req_op;

  // Only the opcode and funct3 fields take part in decode.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{eai_req_instr[XLEN-1:15], eai_req_instr[11:7]};

  assign req_op = decode_op(eai_req_instr[6:0], eai_req_instr[14:12]);

  // Operands go straight into the multiplier's registers on accept, so
  // later changes on rs1/rs2 have no effect.
  e203_eai_copro_mul #(
    .MUL_BPC (MUL_BPC),
    .XLEN    (XLEN)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .op_a    (eai_req_rs1),
    .op_b    (eai_req_rs2),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    rdat_d    = rdat_q;
    err_d     = err_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (eai_req_valid) begin
          op_d = req_op;
          case (req_op)
            OP_MUL, OP_MAC: begin
              mul_start = 1'b1;
              state_d   = ST_EXEC;
            end
            OP_RDACC: begin
              rdat_d  = acc_q;
              err_d   = 1'b0;
              state_d = ST_RSP;
            end
            OP_CLR: begin
              rdat_d  = acc_q;
              acc_d   = '0;
              err_d   = 1'b0;
              state_d = ST_RSP;
            end
            default: begin
              rdat_d  = '0;
              err_d   = 1'b1;
              state_d = ST_RSP;
            end
          endcase
        end
      end
      ST_EXEC: begin
        // Result and accumulator are committed on the edge entering RSP.
        if (mul_done) begin
          err_d   = 1'b0;
          state_d = ST_RSP;
          if (op_q == OP_MAC) begin
            acc_d  = acc_q + mul_product;
            rdat_d = acc_q + mul_product;
          end else begin
            rdat_d = mul_product;
          end
        end
      end
      ST_RSP: begin
        if (eai_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ILLEGAL;
      acc_q   <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
    end
  end

  // All handshake outputs come from registered state only.
  assign eai_req_ready = (state_q == ST_IDLE);
  assign eai_rsp_valid = (state_q == ST_RSP);
  assign copro_busy    = (state_q != ST_IDLE);
  assign eai_rsp_rdat  = rdat_q;
  assign eai_rsp_err   = err_q;

endmodule

// File: tb/tb_e203_eai_copro.sv
// Self-checking bench: directed vector table, hold/abort sequences, randomized
// operations against a behavioural accumulator model, and a MUL_BPC=4 instance.
module tb_e203_eai_copro;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_drv;
  logic        rsp_ready_drv;
  logic        use4;
  logic [31:0] instr, rs1, rs2;

  logic        req_valid1, req_ready1, rsp_valid1, err1, busy1;
  logic [31:0] rdat1;
  logic        req_valid4, req_ready4, rsp_valid4, err4, busy4;
  logic [31:0] rdat4;

  logic        cur_ready, cur_valid, cur_err, cur_busy;
  logic [31:0] cur_rdat;

  always #5 clk = ~clk;

  assign req_valid1 = req_valid_drv & ~use4;
  assign req_valid4 = req_valid_drv & use4;
  assign cur_ready  = use4 ? req_ready4 : req_ready1;
  assign cur_valid  = use4 ? rsp_valid4 : rsp_valid1;
  assign cur_err    = use4 ? err4       : err1;
  assign cur_busy   = use4 ? busy4      : busy1;
  assign cur_rdat   = use4 ? rdat4      : rdat1;

  e203_eai_copro #(.MUL_BPC(1), .XLEN(32)) u_dut (
    .clk(clk), .rst(rst),
    .eai_req_valid(req_valid1), .eai_req_ready(req_ready1),
    .eai_req_instr(instr), .eai_req_rs1(rs1), .eai_req_rs2(rs2),
    .eai_rsp_valid(rsp_valid1), .eai_rsp_ready(rsp_ready_drv),
    .eai_rsp_rdat(rdat1), .eai_rsp_err(err1), .copro_busy(busy1)
  );

  e203_eai_copro #(.MUL_BPC(4), .XLEN(32)) u_dut4 (
    .clk(clk), .rst(rst),
    .eai_req_valid(req_valid4), .eai_req_ready(req_ready4),
    .eai_req_instr(instr), .eai_req_rs1(rs1), .eai_req_rs2(rs2),
    .eai_rsp_valid(rsp_valid4), .eai_rsp_ready(rsp_ready_drv),
    .eai_rsp_rdat(rdat4), .eai_rsp_err(err4), .copro_busy(busy4)
  );

  localparam logic [31:0] I_MUL   = 32'h0000_000B;
  localparam logic [31:0] I_MAC   = 32'h0000_100B;
  localparam logic [31:0] I_RDACC = 32'h0000_200B;
  localparam logic [31:0] I_CLR   = 32'h0000_300B;
  localparam logic [31:0] I_F111  = 32'h0000_700B;
  localparam logic [31:0] I_F100  = 32'h0000_400B;
  localparam logic [31:0] I_BADOP = 32'h0000_0033;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  // Starts and ends on a negedge with the selected DUT idle.
  task automatic run_op(input logic [31:0] i_instr, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_rdat, input logic exp_err, input int exp_lat,
                        input int hold, input string name);
    int  lat;
    bit  seen;
    check({name, " req_ready"}, 32'(cur_ready), 32'd1);
    instr = i_instr; rs1 = a; rs2 = b;
    req_valid_drv = 1'b1;
    rsp_ready_drv = 1'b0;
    @(posedge clk);
    #1;
    req_valid_drv = 1'b0;
    rs1 = $urandom; rs2 = $urandom; instr = $urandom;
    lat = 0; seen = 0;
    while (!seen && lat < 200) begin
      lat++;
      @(negedge clk);
      if (cur_valid) seen = 1;
      else @(posedge clk);
    end
    check({name, " rsp_seen"}, 32'(seen), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " rdat"}, cur_rdat, exp_rdat);
    check({name, " err"}, 32'(cur_err), 32'(exp_err));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check({name, " hold valid"}, 32'(cur_valid), 32'd1);
      check({name, " hold rdat"}, cur_rdat, exp_rdat);
      check({name, " hold err"}, 32'(cur_err), 32'(exp_err));
      check({name, " hold req_ready"}, 32'(cur_ready), 32'd0);
    end
    rsp_ready_drv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_drv = 1'b0;
    check({name, " idle after rsp"}, {30'd0, cur_ready, cur_valid}, 32'd2);
    $display("op %s instr=%08h rs1=%08h rs2=%08h rdat=%08h err=%0d lat=%0d",
             name, i_instr, a, b, exp_rdat, exp_err, exp_lat);
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rdat;
    logic        err;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs[12];

  logic [31:0] acc_m;
  logic [63:0] prod;
  logic [31:0] r_instr, r_a, r_b, r_exp;
  logic        r_err;
  int          r_lat, kind, vcount;

  initial begin
    vecs[0]  = '{I_MUL,   32'd3,         32'd5, 32'd15,        1'b0, 33, "mul_3x5"};
    vecs[1]  = '{I_MAC,   32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 33, "mac_max"};
    vecs[2]  = '{I_RDACC, 32'd0,         32'd0, 32'hFFFF_FFFE, 1'b0, 1,  "rdacc_1"};
    vecs[3]  = '{I_MAC,   32'd1,         32'd2, 32'h0000_0000, 1'b0, 33, "mac_wrap"};
    vecs[4]  = '{I_MAC,   32'h1234_5678, 32'd1, 32'h1234_5678, 1'b0, 33, "mac_load"};
    vecs[5]  = '{I_CLR,   32'd0,         32'd0, 32'h1234_5678, 1'b0, 1,  "clr"};
    vecs[6]  = '{I_RDACC, 32'd0,         32'd0, 32'h0000_0000, 1'b0, 1,  "rdacc_0"};
    vecs[7]  = '{I_MAC,   32'd7,         32'd6, 32'd42,        1'b0, 33, "mac_42"};
    vecs[8]  = '{I_F111,  32'd9,         32'd9, 32'd0,         1'b1, 1,  "ill_f111"};
    vecs[9]  = '{I_RDACC, 32'd0,         32'd0, 32'd42,        1'b0, 1,  "rdacc_42"};
    vecs[10] = '{I_BADOP, 32'd1,         32'd1, 32'd0,         1'b1, 1,  "ill_opc"};
    vecs[11] = '{I_F100,  32'd1,         32'd1, 32'd0,         1'b1, 1,  "ill_f100"};

    use4 = 1'b0; rst = 1'b1; req_valid_drv = 1'b0; rsp_ready_drv = 1'b0;
    instr = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", 32'(req_ready1), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid1), 32'd0);
    check("reset rdat", rdat1, 32'd0);
    check("reset err", 32'(err1), 32'd0);
    check("reset busy", 32'(busy1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].instr, vecs[i].a, vecs[i].b, vecs[i].rdat, vecs[i].err,
             vecs[i].lat, 0, vecs[i].name);
    end
    acc_m = 32'd42;

    // Response held for 10 cycles with rsp_ready low.
    run_op(I_MUL, 32'd9, 32'd9, 32'd81, 1'b0, 33, 10, "mul_hold");

    // Randomized operations against the accumulator model.
    for (int n = 0; n < 40; n++) begin
      kind    = $urandom_range(0, 4);
      r_instr = $urandom;
      r_a     = $urandom;
      r_b     = (n % 4 == 0) ? 32'(($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd0) : $urandom;
      prod    = 64'(r_a) * 64'(r_b);
      r_err   = 1'b0;
      r_lat   = 1;
      r_instr[6:0] = 7'b0001011;
      case (kind)
        0: begin r_instr[14:12] = 3'b000; r_exp = prod[31:0]; r_lat = 33; end
        1: begin r_instr[14:12] = 3'b001; acc_m = acc_m + prod[31:0]; r_exp = acc_m; r_lat = 33; end
        2: begin r_instr[14:12] = 3'b010; r_exp = acc_m; end
        3: begin r_instr[14:12] = 3'b011; r_exp = acc_m; acc_m = 32'd0; end
        default: begin
          if ($urandom_range(0, 1) == 1) r_instr[14:12] = 3'(4 + $urandom_range(0, 3));
          else r_instr[6:0] = 7'(32'h33 + 32'($urandom_range(0, 3)) * 32'h10);
          r_exp = 32'd0; r_err = 1'b1;
        end
      endcase
      run_op(r_instr, r_a, r_b, r_exp, r_err, r_lat, $urandom_range(0, 3), "rand");
    end

    // Reset during EXEC aborts the multiply and clears the accumulator.
    instr = I_MUL; rs1 = 32'd3; rs2 = 32'd5;
    req_valid_drv = 1'b1;
    @(posedge clk);
    #1 req_valid_drv = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("abort busy in exec", 32'(busy1), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort req_ready", 32'(req_ready1), 32'd1);
    check("abort busy", 32'(busy1), 32'd0);
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      if (rsp_valid1) vcount++;
      @(negedge clk);
    end
    check("abort no rsp", 32'(vcount), 32'd0);
    acc_m = 32'd0;
    run_op(I_RDACC, 32'd0, 32'd0, acc_m, 1'b0, 1, 0, "rdacc_after_rst");

    // MUL_BPC=4 instance: eight step cycles.
    use4 = 1'b1;
    @(negedge clk);
    run_op(I_MUL, 32'd3, 32'd5, 32'd15, 1'b0, 9, 0, "bpc4_mul");
    run_op(I_MAC, 32'hDEAD_BEEF, 32'h0000_1234, 32'(64'(32'hDEAD_BEEF) * 64'h1234), 1'b0, 9, 1, "bpc4_mac");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
